// File: rtl/byte_serial_add_seq.sv
// byte_serial_add_seq
// Adds two multi-byte operands that arrive one byte per beat, least-significant
// byte first, carrying between beats. Each accepted beat produces one sum byte
// one cycle later through a single-entry output register. The final beat of a
// packet also reports the carry-out and whether every sum byte was zero.
// Protocol violations raise a sticky error flag but never stall the data.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   in_valid/ready   input handshake; in_ready = !out_valid || out_ready
//   in_a, in_b       operand bytes
//   in_cin           packet carry-in, used only on a first beat
//   in_first/last    packet delimiters (both high = single-byte packet)
//   out_valid/ready  output handshake
//   out_sum          sum byte
//   out_last         result beat closes its packet (also forced on overrun)
//   out_cout         final carry-out, 0 unless out_last
//   out_zero         whole packet summed to zero, 0 unless out_last
//   err              sticky protocol-error flag
module byte_serial_add_seq #(
  parameter int MAX_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_cin,
  input  logic       in_first,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_cout,
  output logic       out_zero,
  output logic       err
);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  // Compared on 5 bits so MAX_BYTES = 16 still fits.
  localparam logic [4:0] MAX_B = 5'(MAX_BYTES);

  state_t     state_q, state_d;
  logic       carry_q, carry_d;
  logic [3:0] cnt_q, cnt_d;
  logic       zero_q, zero_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_sum_q, out_sum_d;
  logic       out_last_q, out_last_d;
  logic       out_cout_q, out_cout_d;
  logic       out_zero_q, out_zero_d;
  logic       err_q, err_d;

  logic       accept;
  logic       is_first;
  logic       cin;
  logic [8:0] sum9;
  logic [4:0] cnt_next;
  logic       forced;
  logic       last_eff;
  logic       zero_all;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A beat opens a new packet either because none is open or because the
  // sender says so; in both cases the carry chain restarts from in_cin.
  assign is_first = (state_q == IDLE) || in_first;
  assign cin      = is_first ? in_cin : carry_q;
  assign sum9     = {1'b0, in_a} + {1'b0, in_b} + {8'b0, cin};
  assign cnt_next = is_first ? 5'd1 : ({1'b0, cnt_q} + 5'd1);
  // Overrun: packet hits its length limit without a last marker.
  assign forced   = !in_last && (cnt_next == MAX_B);
  assign last_eff = in_last || forced;
  assign zero_all = (is_first ? 1'b1 : zero_q) && (sum9[7:0] == 8'd0);

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_zero_d  = out_zero_q;
    err_d       = err_q;

    if (accept) begin
      // An accepted beat always overwrites the output register, which also
      // covers the case where the held result is consumed in the same cycle.
      out_valid_d = 1'b1;
      out_sum_d   = sum9[7:0];
      out_last_d  = last_eff;
      out_cout_d  = last_eff ? sum9[8] : 1'b0;
      out_zero_d  = last_eff ? zero_all : 1'b0;
      state_d     = last_eff ? IDLE : BODY;
      carry_d     = last_eff ? 1'b0 : sum9[8];
      zero_d      = last_eff ? 1'b1 : zero_all;
      cnt_d       = cnt_next[3:0];
      if (((state_q == IDLE) && !in_first) ||
          ((state_q == BODY) && in_first) || forced) begin
        err_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      cnt_q       <= 4'd0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= 8'd0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_zero_q  <= out_zero_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_zero  = out_zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Directed testbench for byte_serial_add_seq (MAX_BYTES = 4).
// Inputs are driven 1 ns after a rising edge and outputs sampled there too.
module tb_byte_serial_add_seq;

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic       inReady;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       inCin;
  logic       inFirst;
  logic       inLast;
  logic       outValid;
  logic       outReady;
  logic [7:0] outSum;
  logic       outLast;
  logic       outCout;
  logic       outZero;
  logic       err;

  int errorCount = 0;
  int checkCount = 0;

  byte_serial_add_seq #(.MAX_BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_a      (inA),
    .in_b      (inB),
    .in_cin    (inCin),
    .in_first  (inFirst),
    .in_last   (inLast),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_sum   (outSum),
    .out_last  (outLast),
    .out_cout  (outCout),
    .out_zero  (outZero),
    .err       (err)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one beat, waits (bounded) until it is accepted, then drops
  // in_valid. Returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic first,
                               input logic last);
    int waitCycles;
    inA = a; inB = b; inCin = c; inFirst = first; inLast = last;
    inValid = 1'b1;
    waitCycles = 0;
    while (!inReady && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (waitCycles >= 20) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  // Checks the full result beat registered by the previous accept.
  task automatic expectBeat(input string tag, input logic [7:0] sum,
                            input logic last, input logic cout,
                            input logic zero, input logic e);
    checkOutput({tag, ".valid"}, {31'd0, outValid}, 32'd1);
    checkOutput({tag, ".sum"},   {24'd0, outSum},   {24'd0, sum});
    checkOutput({tag, ".last"},  {31'd0, outLast},  {31'd0, last});
    checkOutput({tag, ".cout"},  {31'd0, outCout},  {31'd0, cout});
    checkOutput({tag, ".zero"},  {31'd0, outZero},  {31'd0, zero});
    checkOutput({tag, ".err"},   {31'd0, err},      {31'd0, e});
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
    inA = '0; inB = '0; inCin = 1'b0; inFirst = 1'b0; inLast = 1'b0;
    #1;
    checkOutput("rst.valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst.ready", {31'd0, inReady},  32'd1);
    checkOutput("rst.sum",   {24'd0, outSum},   32'd0);
    checkOutput("rst.last",  {31'd0, outLast},  32'd0);
    checkOutput("rst.cout",  {31'd0, outCout},  32'd0);
    checkOutput("rst.zero",  {31'd0, outZero},  32'd0);
    checkOutput("rst.err",   {31'd0, err},      32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("post_rst.ready", {31'd0, inReady}, 32'd1);

    // Single-byte packet: FF + 01 = 0x100.
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
    expectBeat("single", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // 0x00FFFFFF + 0x00000001: carry ripples through three bytes.
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    expectBeat("four.b0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    expectBeat("four.b1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    expectBeat("four.b2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    expectBeat("four.b3", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

    // Two-byte all-zero packet reports out_zero.
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    expectBeat("zero.b0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    expectBeat("zero.b1", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("drain.valid", {31'd0, outValid}, 32'd0);

    // Backpressure: hold first result for 3 cycles while beat 2 waits.
    outReady = 1'b0;
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
    expectBeat("bp.b0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    inA = 8'h01; inB = 8'h02; inCin = 1'b0; inFirst = 1'b0; inLast = 1'b1;
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("bp.hold.ready", {31'd0, inReady},  32'd0);
      checkOutput("bp.hold.valid", {31'd0, outValid}, 32'd1);
      checkOutput("bp.hold.sum",   {24'd0, outSum},   32'h00);
      checkOutput("bp.hold.last",  {31'd0, outLast},  32'd0);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    expectBeat("bp.b1", 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("bp.drain.valid", {31'd0, outValid}, 32'd0);

    // Overrun: four beats without last, the fourth is forced closed.
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    expectBeat("ovr.b0", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    expectBeat("ovr.b1", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    expectBeat("ovr.b2", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    expectBeat("ovr.b3", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    // Fifth beat starts afresh from in_cin=0 (stale carry would give 0x31).
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    expectBeat("ovr.b4", 8'h30, 1'b1, 1'b0, 1'b0, 1'b1);

    // Protocol errors after a fresh reset.
    doReset();
    checkOutput("perr.rst.err", {31'd0, err}, 32'd0);
    applyStimulus(8'hFF, 8'h06, 1'b1, 1'b0, 1'b0);
    expectBeat("perr.nofirst", 8'h06, 1'b0, 1'b0, 1'b0, 1'b1);
    // Carry of 1 is pending; in_first mid-packet restarts from in_cin=0.
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    expectBeat("perr.midfirst", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset mid-packet with a result held on the output.
    doReset();
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("mrst.pre.valid", {31'd0, outValid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mrst.valid", {31'd0, outValid}, 32'd0);
    checkOutput("mrst.ready", {31'd0, inReady},  32'd1);
    checkOutput("mrst.err",   {31'd0, err},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    expectBeat("mrst.next", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
